// File: rtl/synth_voice.sv
// synth_voice: one synthesizer voice.
// A prescaler divides clk into a sample tick. On each tick the phase
// accumulator advances by pitch_increment. The selected waveforms (pulse, saw,
// triangle, and noise if present) are ANDed together. The combined wave is
// scaled by an attack/sustain/release envelope and registered to out.
//
// Optional feature macro: SYNTH_VOICE_NOISE_EN
//   defined     -> 23-bit LFSR and noise waveform present (voice_select[3])
//   not defined -> no LFSR; voice_select[3] is ignored
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-low reset
//   voice_select     [0] pulse, [1] saw, [2] triangle, [3] noise
//   pitch_increment  phase step per sample tick
//   envelope_attack  envelope increment per tick while attacking
//   envelope_decay   envelope decrement per tick while releasing
//   gate             note on (1) / off (0)
//   sample_tick      one-clk pulse; the voice updates on the following edge
//   out              unsigned sample
//
// Envelope states:
//   state     | meaning
//   S_IDLE    | silent, env = 0
//   S_ATTACK  | env rising by envelope_attack per tick, saturating at 0xFFFF
//   S_SUSTAIN | env held at 0xFFFF while gate is high
//   S_RELEASE | env falling by envelope_decay per tick, saturating at 0
module synth_voice #(
  parameter int BITDEPTH        = 14,
  parameter int BITFRACTION     = 6,
  parameter int SAMPLECLOCK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          voice_select,
  input  logic [15:0]         pitch_increment,
  input  logic [7:0]          envelope_attack,
  input  logic [7:0]          envelope_decay,
  input  logic                gate,
  output logic                sample_tick,
  output logic [BITDEPTH-1:0] out
);

  localparam int ACC_W = BITDEPTH + BITFRACTION;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATTACK,
    S_SUSTAIN,
    S_RELEASE
  } env_state_t;

  logic [SAMPLECLOCK_DIV-1:0] presc;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_next;
  logic [BITDEPTH-1:0]        phase;
  logic [BITDEPTH-1:0]        saw;
  logic [BITDEPTH-1:0]        pulse;
  logic [BITDEPTH-1:0]        tri_fold;
  logic [BITDEPTH-1:0]        tri_wave;
  logic [BITDEPTH-1:0]        wave;
  logic                       any_sel;
  logic [BITDEPTH+7:0]        prod;

  env_state_t                 state, state_nx;
  logic [15:0]                env, env_nx;
  logic [16:0]                env_up, env_dn;
  logic                       gate_prev;
  logic                       tick;

  // The registered tick is high for the one clk before the update edge.
  assign tick = sample_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      sample_tick <= 1'b0;
    end else begin
      presc       <= presc + 1'b1;
      sample_tick <= &presc;
    end
  end

  assign acc_next = acc + ACC_W'(pitch_increment);
  assign phase    = acc[ACC_W-1 -: BITDEPTH];
  assign saw      = phase;
  assign pulse    = {BITDEPTH{phase[BITDEPTH-1]}};
  assign tri_fold = phase[BITDEPTH-1] ? ~phase : phase;
  assign tri_wave = {tri_fold[BITDEPTH-2:0], 1'b0};

`ifdef SYNTH_VOICE_NOISE_EN
  localparam int STEP_BIT = BITFRACTION + BITDEPTH - 4;

  logic [22:0]         lfsr;
  logic [BITDEPTH-1:0] noise;

  assign noise = lfsr[22 -: BITDEPTH];

  // The LFSR clocks when the accumulator bit rises across this tick's add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= '1;
    end else if (tick && !acc[STEP_BIT] && acc_next[STEP_BIT]) begin
      lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
    end
  end
`else
  logic unused_noise_sel;
  assign unused_noise_sel = voice_select[3];
`endif

  always_comb begin
    wave    = '1;
    any_sel = 1'b0;
    if (voice_select[0]) begin
      wave    = wave & pulse;
      any_sel = 1'b1;
    end
    if (voice_select[1]) begin
      wave    = wave & saw;
      any_sel = 1'b1;
    end
    if (voice_select[2]) begin
      wave    = wave & tri_wave;
      any_sel = 1'b1;
    end
`ifdef SYNTH_VOICE_NOISE_EN
    if (voice_select[3]) begin
      wave    = wave & noise;
      any_sel = 1'b1;
    end
`endif
    if (!any_sel) begin
      wave = '0;
    end
  end

  assign prod = (BITDEPTH+8)'(wave) * (BITDEPTH+8)'(env[15:8]);

  // 17-bit sums expose overflow/borrow for the saturating envelope steps.
  assign env_up = {1'b0, env} + {9'b0, envelope_attack};
  assign env_dn = {1'b0, env} - {9'b0, envelope_decay};

  always_comb begin
    state_nx = state;
    env_nx   = env;
    if (gate && !gate_prev) begin
      state_nx = S_ATTACK;
    end else begin
      case (state)
        S_IDLE: begin
          env_nx = '0;
        end
        S_ATTACK: begin
          if (!gate) begin
            state_nx = S_RELEASE;
          end else if (envelope_attack == 8'd0 || env_up[16] || env_up[15:0] == 16'hFFFF) begin
            env_nx   = 16'hFFFF;
            state_nx = S_SUSTAIN;
          end else begin
            env_nx = env_up[15:0];
          end
        end
        S_SUSTAIN: begin
          env_nx = 16'hFFFF;
          if (!gate) begin
            state_nx = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (envelope_decay == 8'd0 || env_dn[16] || env_dn[15:0] == 16'd0) begin
            env_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            env_nx = env_dn[15:0];
          end
        end
        default: begin
          env_nx   = '0;
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Output uses the pre-update env and acc: a one-sample pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      env       <= '0;
      gate_prev <= 1'b0;
      acc       <= '0;
      out       <= '0;
    end else if (tick) begin
      state     <= state_nx;
      env       <= env_nx;
      gate_prev <= gate;
      acc       <= acc_next;
      out       <= prod[BITDEPTH+7:8];
    end
  end

endmodule

// File: tb/tb_synth_voice.sv
module tb_synth_voice;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  voice_select = 4'b0000;
  logic [15:0] pitch_increment = 16'd0;
  logic [7:0]  envelope_attack = 8'd0;
  logic [7:0]  envelope_decay = 8'd0;
  logic        gate = 1'b0;
  logic        sample_tick;
  logic [13:0] out;

  int errors = 0;
  int checks = 0;

  synth_voice dut (
    .clk             (clk),
    .rst             (rst),
    .voice_select    (voice_select),
    .pitch_increment (pitch_increment),
    .envelope_attack (envelope_attack),
    .envelope_decay  (envelope_decay),
    .gate            (gate),
    .sample_tick     (sample_tick),
    .out             (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait for the next sample tick, then for the update edge that follows it.
  // Returns at a negedge with the new out visible.
  task automatic tick();
    int n;
    n = 0;
    @(negedge clk);
    while (sample_tick !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sample_tick !== 1'b1) chk("tick_timeout", 32'(sample_tick), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int n;

    repeat (10) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_tick", 32'(sample_tick), 32'd0);
    rst = 1'b1;

    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (sample_tick === 1'b1) break;
    end
    chk("first_tick_clks", 32'(n), 32'd256);

    // T1: gate edge, saw, pitch 0x1000 (phase steps 0x40 per tick)
    gate = 1'b1; voice_select = 4'b0010; pitch_increment = 16'h1000; envelope_attack = 8'd0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_out", 32'(out), 32'd0);
    chk("tick_one_clk", 32'(sample_tick), 32'd0);
    tick(); chk("t2_env_pipeline", 32'(out), 32'd0);
    tick(); chk("t3_saw", 32'(out), 32'd127);
    tick(); chk("t4_saw", 32'(out), 32'd191);

    voice_select = 4'b0001; pitch_increment = 16'h8000;
    tick(); chk("t5_pulse_low", 32'(out), 32'd0);
    repeat (14) tick();
    tick(); chk("t20_pulse_low", 32'(out), 32'd0);
    tick(); chk("t21_pulse_high", 32'(out), 32'd16319);

    voice_select = 4'b0100;
    tick(); chk("t22_triangle", 32'(out), 32'd14788);
    voice_select = 4'b0011;
    tick(); chk("t23_pulse_and_saw", 32'(out), 32'd9435);
    voice_select = 4'b0000;
    tick(); chk("t24_no_select", 32'(out), 32'd0);

    voice_select = 4'b0010; gate = 1'b0; envelope_decay = 8'd0;
    tick(); chk("t25_release_entry", 32'(out), 32'd10455);
    tick(); chk("t26_saw", 32'(out), 32'd10965);
    tick(); chk("t27_decay0_silent", 32'(out), 32'd0);

    // Freeze phase in the upper half: pulse = 0x3FFF, out = 64*env_hi - 1.
    gate = 1'b1; envelope_attack = 8'h80; voice_select = 4'b0001; pitch_increment = 16'h0000;
    tick(); tick(); tick();
    tick(); chk("t31_attack_step", 32'(out), 32'd63);
    tick();
    tick(); chk("t33_attack_step", 32'(out), 32'd127);
    envelope_attack = 8'd0;
    tick();
    tick(); chk("t35_attack0_full", 32'(out), 32'd16319);

    gate = 1'b0; envelope_decay = 8'h80;
    tick(); tick(); tick();
    tick(); chk("t39_release_step", 32'(out), 32'd16255);
    gate = 1'b1; envelope_attack = 8'h40;
    tick();
    tick(); chk("t41_retrigger_keeps_env", 32'(out), 32'd16255);
    tick(); tick();
    tick(); chk("t44_attack_resumes", 32'(out), 32'd16319);
    envelope_attack = 8'hFF;
    tick();
    tick(); chk("t46_attack_saturates", 32'(out), 32'd16319);
    tick(); chk("t47_sustain_hold", 32'(out), 32'd16319);

    gate = 1'b0; envelope_decay = 8'd0;
    tick(); tick();
    tick(); chk("t50_decay0_idle", 32'(out), 32'd0);

    gate = 1'b1; envelope_attack = 8'h80;
    tick(); tick(); tick();
    gate = 1'b0; envelope_decay = 8'hC0;
    tick(); chk("t54_small_env", 32'(out), 32'd63);
    tick(); tick();
    tick(); chk("t57_release_floor", 32'(out), 32'd0);
    tick(); chk("t58_idle_silent", 32'(out), 32'd0);

    gate = 1'b1; envelope_attack = 8'd0; voice_select = 4'b1000;
    tick(); tick();
    tick();
`ifdef SYNTH_VOICE_NOISE_EN
    chk("t61_noise_present", 32'(out != 14'd0), 32'd1);
`else
    chk("t61_noise_absent", 32'(out), 32'd0);
    voice_select = 4'b1010;
    tick(); chk("t62_sel3_ignored", 32'(out), 32'd11985);
`endif

    #2 rst = 1'b0;
    #1 chk("midnote_reset_out", 32'(out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    voice_select = 4'b0010; pitch_increment = 16'h0040; envelope_attack = 8'd0;
    tick(); tick();
    tick(); chk("r3_after_reset", 32'(out), 32'd1);
    tick(); chk("r4_after_reset", 32'(out), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
